// File: rtl/p4_router_pkg.sv
// ---------------------------------------------------------------------------
// p4_router_pkg
//   Shared definitions for the P4 router egress path: AXIS beat widths,
//   position of the RTL egress id inside the VNP4 user metadata word, the
//   RTL egress id encoding and the egress demux FSM state type.
// ---------------------------------------------------------------------------
package p4_router_pkg;

    // AXIS beat geometry of the VNP4 output and of every egress stream
    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    // user_metadata_out layout: [15:8] RTL egress id, [7:0] P4 ingress id
    localparam int META_EGR_ID_MSB = 15;
    localparam int META_EGR_ID_LSB = 8;

    // RTL egress ids; anything at or above NUM_RTL_EGR is unmapped
    typedef enum logic [7:0] {
        EGR_CPU  = 8'd0,
        EGR_PHY0 = 8'd1,
        EGR_PHY1 = 8'd2,
        EGR_PHY2 = 8'd3,
        EGR_PHY3 = 8'd4,
        EGR_PHY4 = 8'd5,
        EGR_PHY5 = 8'd6,
        EGR_ECG0 = 8'd7,
        EGR_ECG1 = 8'd8,
        EGR_ECG2 = 8'd9,
        EGR_ECG3 = 8'd10,
        EGR_NONE = 8'hFF
    } rtl_egr_ids;

    localparam int NUM_RTL_EGR = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/p4_router_meta_fifo.sv
// ---------------------------------------------------------------------------
// p4_router_meta_fifo
//   Generic synchronous FIFO. A push to a full FIFO is discarded unless a pop
//   happens in the same cycle; the discarded push is flagged on 'overflow'
//   for that cycle only. Pop on empty is ignored.
// Ports
//   clk, areset           clock, asynchronous active-high reset
//   push, push_data       write request and word
//   pop                   read request (advances head)
//   head                  word at the head of the FIFO (valid when !empty)
//   full, empty           occupancy flags
//   overflow              single-cycle pulse: push lost because FIFO full
// ---------------------------------------------------------------------------
module p4_router_meta_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; its contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/p4_router_egress_demux.sv
// ---------------------------------------------------------------------------
// p4_router_egress_demux
//   Steers packets from the VNP4 AXIS output to one of NUM_EGRESS egress
//   streams using the RTL egress id carried in the per-packet metadata word.
//   Metadata words are buffered in a small FIFO; packets with an unmapped
//   egress id are consumed at full rate and counted.
// Ports
//   clk, areset             clock, asynchronous active-high reset
//   data_in_t*              VNP4 packet stream (tdata/tkeep/tlast/tvalid/tready)
//   meta_in, meta_in_valid  metadata word, one single-cycle pulse per packet
//   egress_t*               NUM_EGRESS egress streams (packed per port)
//   drop_count              saturating count of dropped packets
//   meta_overflow           sticky: a metadata word was lost to a full FIFO
//   stats_clear             synchronous clear of drop_count and meta_overflow
// ---------------------------------------------------------------------------
module p4_router_egress_demux
    import p4_router_pkg::*;
#(
    parameter int USER_METADATA_WIDTH = 16,
    parameter int NUM_EGRESS          = 11,
    parameter int META_FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 areset,
    input  logic [DATA_W-1:0]                    data_in_tdata,
    input  logic [KEEP_W-1:0]                    data_in_tkeep,
    input  logic                                 data_in_tlast,
    input  logic                                 data_in_tvalid,
    output logic                                 data_in_tready,
    input  logic [USER_METADATA_WIDTH-1:0]       meta_in,
    input  logic                                 meta_in_valid,
    output logic [NUM_EGRESS-1:0][DATA_W-1:0]    egress_tdata,
    output logic [NUM_EGRESS-1:0][KEEP_W-1:0]    egress_tkeep,
    output logic [NUM_EGRESS-1:0]                egress_tlast,
    output logic [NUM_EGRESS-1:0]                egress_tvalid,
    input  logic [NUM_EGRESS-1:0]                egress_tready,
    output logic [31:0]                          drop_count,
    output logic                                 meta_overflow,
    input  logic                                 stats_clear
);

    localparam int SEL_W = (NUM_EGRESS > 1) ? $clog2(NUM_EGRESS) : 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    fsm_state_t                     state;
    fsm_state_t                     state_nxt;
    logic [USER_METADATA_WIDTH-1:0] fifo_head;
    logic                           fifo_empty;
    logic                           fifo_full_unused;
    logic                           fifo_ovf;
    logic                           fifo_pop;
    logic [7:0]                     head_egr_id;
    logic                           id_mapped;
    logic                           sel_load;
    logic [SEL_W-1:0]               route_sel;
    logic                           drop_inc;
    logic                           out_ready;
    logic                           beat_acc;
    logic                           unused_meta_bits;

    logic [DATA_W-1:0]              out_data_p1;
    logic [KEEP_W-1:0]              out_keep_p1;
    logic                           out_last_p1;
    logic                           vld_p1;
    logic [SEL_W-1:0]               out_sel_p1;

    p4_router_meta_fifo #(
        .WIDTH (USER_METADATA_WIDTH),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk       (clk),
        .areset    (areset),
        .push      (meta_in_valid),
        .push_data (meta_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf)
    );

    // Only the egress id field steers; the ingress id rides along unused
    assign unused_meta_bits = ^fifo_head;
    assign head_egr_id      = fifo_head[META_EGR_ID_MSB:META_EGR_ID_LSB];
    assign id_mapped        = ({24'd0, head_egr_id} < 32'(NUM_EGRESS));

    // Output register can take a new beat when empty or being drained
    assign out_ready = !vld_p1 || |(egress_tready & egress_tvalid);
    assign beat_acc  = (state == ROUTE) && out_ready && data_in_tvalid;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            route_sel <= '0;
        end else begin
            state <= state_nxt;
            if (sel_load) route_sel <= head_egr_id[SEL_W-1:0];
        end
    end

    always_comb begin
        state_nxt      = state;
        data_in_tready = 1'b0;
        fifo_pop       = 1'b0;
        drop_inc       = 1'b0;
        sel_load       = 1'b0;
        unique case (state)
            IDLE: begin
                // Packets never start before their metadata is available
                if (!fifo_empty && data_in_tvalid) begin
                    sel_load  = 1'b1;
                    state_nxt = id_mapped ? ROUTE : DROP;
                end
            end
            ROUTE: begin
                data_in_tready = out_ready;
                if (beat_acc && data_in_tlast) begin
                    fifo_pop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                data_in_tready = 1'b1;
                if (data_in_tvalid && data_in_tlast) begin
                    fifo_pop  = 1'b1;
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0 -> p1: shared egress output register ----
    // out_sel_p1 only reloads with an accepted beat, which requires the
    // previous beat (including a tlast) to have been taken by its port.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld_p1     <= 1'b0;
            out_sel_p1 <= '0;
        end else if (out_ready) begin
            vld_p1 <= beat_acc;
            if (beat_acc) out_sel_p1 <= route_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_acc) begin
            out_data_p1 <= data_in_tdata;
            out_keep_p1 <= data_in_tkeep;
            out_last_p1 <= data_in_tlast;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_EGRESS; i++) begin
            egress_tvalid[i] = vld_p1 && (out_sel_p1 == SEL_W'(i));
        end
    end

    assign egress_tdata = {NUM_EGRESS{out_data_p1}};
    assign egress_tkeep = {NUM_EGRESS{out_keep_p1}};
    assign egress_tlast = {NUM_EGRESS{out_last_p1}};

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            drop_count    <= '0;
            meta_overflow <= 1'b0;
        end else if (stats_clear) begin
            drop_count    <= '0;
            meta_overflow <= 1'b0;
        end else begin
            if (drop_inc) drop_count    <= sat_inc32(drop_count);
            if (fifo_ovf) meta_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_p4_router_egress_demux.sv
module tb_p4_router_egress_demux;
    import p4_router_pkg::*;

    localparam int NE = 11;

    logic                     clk = 1'b0;
    logic                     areset = 1'b1;
    logic [63:0]              data_in_tdata = '0;
    logic [7:0]               data_in_tkeep = '0;
    logic                     data_in_tlast = 1'b0;
    logic                     data_in_tvalid = 1'b0;
    logic                     data_in_tready;
    logic [15:0]              meta_in = '0;
    logic                     meta_in_valid = 1'b0;
    logic [NE-1:0][63:0]      egress_tdata;
    logic [NE-1:0][7:0]       egress_tkeep;
    logic [NE-1:0]            egress_tlast;
    logic [NE-1:0]            egress_tvalid;
    logic [NE-1:0]            egress_tready = '1;
    logic [31:0]              drop_count;
    logic                     meta_overflow;
    logic                     stats_clear = 1'b0;

    always #5 clk = ~clk;

    p4_router_egress_demux #(
        .USER_METADATA_WIDTH (16),
        .NUM_EGRESS          (NE),
        .META_FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .data_in_tdata  (data_in_tdata),
        .data_in_tkeep  (data_in_tkeep),
        .data_in_tlast  (data_in_tlast),
        .data_in_tvalid (data_in_tvalid),
        .data_in_tready (data_in_tready),
        .meta_in        (meta_in),
        .meta_in_valid  (meta_in_valid),
        .egress_tdata   (egress_tdata),
        .egress_tkeep   (egress_tkeep),
        .egress_tlast   (egress_tlast),
        .egress_tvalid  (egress_tvalid),
        .egress_tready  (egress_tready),
        .drop_count     (drop_count),
        .meta_overflow  (meta_overflow),
        .stats_clear    (stats_clear)
    );

    typedef struct {
        int          port;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    beat_t  beats[$];
    beat_t  mon_b;
    int     vld_cnt[NE] = '{default: 0};
    int     rdy_viol = 0;
    logic   rnd5 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress monitor: handshakes are sampled mid-cycle, inputs change just after posedge
    always @(negedge clk) begin
        for (int i = 0; i < NE; i++) begin
            if (egress_tvalid[i]) vld_cnt[i] = vld_cnt[i] + 1;
            if (egress_tvalid[i] && egress_tready[i]) begin
                mon_b.port = i;
                mon_b.data = egress_tdata[i];
                mon_b.keep = egress_tkeep[i];
                mon_b.last = egress_tlast[i];
                mon_b.cyc  = cyc;
                beats.push_back(mon_b);
            end
        end
        if (!areset && data_in_tready && (|egress_tvalid) && !(|(egress_tvalid & egress_tready)))
            rdy_viol = rdy_viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] bdata(input int ptag, input int i);
        return {32'(ptag), 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_meta(input logic [7:0] egr, input logic [7:0] ing);
        meta_in       = {egr, ing};
        meta_in_valid = 1'b1;
        tick();
        meta_in_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic acc;
        acc            = 1'b0;
        data_in_tdata  = d;
        data_in_tkeep  = k;
        data_in_tlast  = l;
        data_in_tvalid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = data_in_tready;
            @(posedge clk);
            #1;
            if (rnd5) egress_tready[5] = 1'($urandom_range(0, 1));
        end
        data_in_tvalid = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_pkt(input int ptag, input int n);
        for (int i = 0; i < n; i++)
            send_beat(bdata(ptag, i), (i == n - 1) ? 8'h0F : 8'hFF, (i == n - 1));
    endtask

    task automatic chk_pkt(input string tag, input int port, input int ptag, input int n, input int base);
        chk($sformatf("%s_nbeats", tag), 64'(beats.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < beats.size()) begin
                chk($sformatf("%s_port%0d", tag, i), 64'(beats[base+i].port), 64'(port));
                chk($sformatf("%s_data%0d", tag, i), beats[base+i].data, bdata(ptag, i));
                chk($sformatf("%s_keep%0d", tag, i), 64'(beats[base+i].keep),
                    64'((i == n - 1) ? 8'h0F : 8'hFF));
                chk($sformatf("%s_last%0d", tag, i), 64'(beats[base+i].last), 64'(i == n - 1));
            end
        end
    endtask

    int vsnap[NE];

    task automatic chk_quiet(input string tag, input int allowed);
        int extra;
        extra = 0;
        for (int i = 0; i < NE; i++)
            if (i != allowed) extra += vld_cnt[i] - vsnap[i];
        chk(tag, 64'(extra), 64'd0);
    endtask

    int   base;
    int   t0;
    int   viol0;
    logic rdy_seen;
    int   t5_ports[4] = '{1, 2, 4, 6};

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_egress_tvalid", 64'(egress_tvalid), 64'd0);
        chk("rst_data_in_tready", 64'(data_in_tready), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_meta_overflow", 64'(meta_overflow), 64'd0);
        areset = 1'b0;
        repeat (2) tick();

        // 4-beat packet to egress 3, latency and throughput
        push_meta(8'h03, 8'h01);
        tick();
        base = beats.size();
        vsnap = vld_cnt;
        t0 = cyc;
        send_pkt(1, 4);
        chk("t1_duration", 64'(cyc - t0), 64'd5);
        repeat (3) tick();
        chk_pkt("t1", 3, 1, 4, base);
        if (beats.size() > base) chk("t1_first_latency", 64'(beats[base].cyc - t0), 64'd2);
        chk_quiet("t1_other_tvalid", 3);

        // Packet arrives 5 cycles before its metadata
        base = beats.size();
        vsnap = vld_cnt;
        data_in_tdata  = bdata(2, 0);
        data_in_tkeep  = 8'hFF;
        data_in_tlast  = 1'b0;
        data_in_tvalid = 1'b1;
        rdy_seen = 1'b0;
        repeat (5) begin
            tick();
            rdy_seen |= data_in_tready;
        end
        push_meta(8'h07, 8'h02);
        rdy_seen |= data_in_tready;
        chk("t2_tready_before_meta", 64'(rdy_seen), 64'd0);
        send_pkt(2, 2);
        repeat (3) tick();
        chk_pkt("t2", 7, 2, 2, base);
        chk("t2_drop_count", 64'(drop_count), 64'd0);
        chk_quiet("t2_other_tvalid", 7);

        // Unmapped 0xFF: consumed at full rate, counted, nothing emitted
        push_meta(8'hFF, 8'h03);
        tick();
        base = beats.size();
        vsnap = vld_cnt;
        t0 = cyc;
        send_pkt(3, 3);
        chk("t3_drop_duration", 64'(cyc - t0), 64'd4);
        repeat (2) tick();
        chk("t3_drop_count", 64'(drop_count), 64'd1);
        chk("t3_drop_nbeats", 64'(beats.size() - base), 64'd0);
        chk_quiet("t3_drop_tvalid", -1);

        push_meta(8'h00, 8'h04);
        tick();
        base = beats.size();
        send_pkt(4, 2);
        repeat (3) tick();
        chk_pkt("t3_next", 0, 4, 2, base);

        // Egress id boundary: 11 unmapped, 10 mapped (single-beat packets)
        push_meta(8'h0B, 8'h05);
        tick();
        base = beats.size();
        send_pkt(5, 1);
        repeat (2) tick();
        chk("t3_id11_drop_count", 64'(drop_count), 64'd2);
        chk("t3_id11_nbeats", 64'(beats.size() - base), 64'd0);
        push_meta(8'h0A, 8'h06);
        tick();
        base = beats.size();
        send_pkt(6, 1);
        repeat (3) tick();
        chk_pkt("t3_id10", 10, 6, 1, base);

        // Random backpressure on egress 5
        push_meta(8'h05, 8'h07);
        tick();
        base = beats.size();
        vsnap = vld_cnt;
        viol0 = rdy_viol;
        rnd5 = 1'b1;
        send_pkt(7, 6);
        rnd5 = 1'b0;
        egress_tready[5] = 1'b1;
        repeat (4) tick();
        chk_pkt("t4", 5, 7, 6, base);
        chk("t4_tready_vs_out_ready", 64'(rdy_viol - viol0), 64'd0);
        chk_quiet("t4_other_tvalid", 5);

        // Five metadata pulses into a depth-4 FIFO
        push_meta(8'h01, 8'h10);
        push_meta(8'h02, 8'h11);
        push_meta(8'h04, 8'h12);
        push_meta(8'h06, 8'h13);
        push_meta(8'h09, 8'h14);
        chk("t5_meta_overflow", 64'(meta_overflow), 64'd1);
        for (int k = 0; k < 4; k++) begin
            base = beats.size();
            send_pkt(10 + k, k + 1);
            repeat (3) tick();
            chk_pkt($sformatf("t5_pkt%0d", k), t5_ports[k], 10 + k, k + 1, base);
        end
        base = beats.size();
        data_in_tdata  = bdata(14, 0);
        data_in_tkeep  = 8'h0F;
        data_in_tlast  = 1'b1;
        data_in_tvalid = 1'b1;
        rdy_seen = 1'b0;
        repeat (4) begin
            tick();
            rdy_seen |= data_in_tready;
        end
        chk("t5_fifth_discarded", 64'(rdy_seen), 64'd0);
        push_meta(8'h09, 8'h15);
        send_pkt(14, 1);
        repeat (3) tick();
        chk_pkt("t5_late", 9, 14, 1, base);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("t5_clear_overflow", 64'(meta_overflow), 64'd0);
        chk("t5_clear_drop_count", 64'(drop_count), 64'd0);

        // Reset mid-packet with a stalled beat held in the output register
        egress_tready[2] = 1'b0;
        push_meta(8'h02, 8'h20);
        tick();
        send_beat(bdata(20, 0), 8'hFF, 1'b0);
        tick();
        chk("t6_pre_tvalid2", 64'(egress_tvalid[2]), 64'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("t6_rst_tvalid", 64'(egress_tvalid), 64'd0);
        chk("t6_rst_tready", 64'(data_in_tready), 64'd0);
        tick();
        tick();
        areset = 1'b0;
        egress_tready[2] = 1'b1;
        tick();
        base = beats.size();
        data_in_tdata  = bdata(21, 0);
        data_in_tkeep  = 8'hFF;
        data_in_tlast  = 1'b0;
        data_in_tvalid = 1'b1;
        rdy_seen = 1'b0;
        repeat (4) begin
            tick();
            rdy_seen |= data_in_tready;
        end
        chk("t6_fifo_empty", 64'(rdy_seen), 64'd0);
        push_meta(8'h04, 8'h21);
        send_pkt(21, 2);
        repeat (3) tick();
        chk_pkt("t6_after", 4, 21, 2, base);
        chk("t6_drop_count", 64'(drop_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
